// File: rtl/vga_blit.sv
// vga_blit: rectangle fill/copy engine acting as a bus initiator on the
// picosoc MMIO bus, targeting the VGA VRAM/font-RAM responder.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort, mode    control: start request, stop request, 0=fill 1=copy
//   src_base, dst_base    copy source / destination byte addresses (word aligned)
//   width, height         rectangle size in words and rows (0 = nothing to do)
//   src_stride/dst_stride byte distance between row starts
//   fill_data, fill_wstrb fill pattern and byte enables for every write
//   busy, done, aborted   status: running, end pulse, ended-by-abort flag
//   sel, wstrb, addr,     bus request and beat fields (wstrb=0 is a read)
//   wdata, ready, rdata   responder completion pulse and read data
module vga_blit #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DIM_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [15:0]       src_stride,
  input  logic [15:0]       dst_stride,
  input  logic [31:0]       fill_data,
  input  logic [3:0]        fill_wstrb,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              sel,
  output logic [3:0]        wstrb,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              ready,
  input  logic [31:0]       rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_GAP_R, S_WRITE, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic              sel_q, sel_d, mode_q, mode_d;
  logic [3:0]        wstrb_q, wstrb_d, wstrb_cfg_q, wstrb_cfg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] src_row_q, src_row_d, src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_row_q, dst_row_d, dst_ptr_q, dst_ptr_d;
  logic [15:0]       src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [DIM_W-1:0]  width_q, width_d, col_q, col_d, row_q, row_d;

  logic [ADDR_W-1:0] src_base_a, dst_base_a;
  logic [ADDR_W-1:0] src_row_nx, dst_row_nx, src_step, dst_step;
  logic              last_col, last_word;

  assign src_base_a = {src_base[ADDR_W-1:2], 2'b00};
  assign dst_base_a = {dst_base[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    sel_d        = sel_q;
    mode_d       = mode_q;
    wstrb_d      = wstrb_q;
    wstrb_cfg_d  = wstrb_cfg_q;
    addr_d       = addr_q;
    src_row_d    = src_row_q;
    src_ptr_d    = src_ptr_q;
    dst_row_d    = dst_row_q;
    dst_ptr_d    = dst_ptr_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    wdata_d      = wdata_q;
    width_d      = width_q;
    col_d        = col_q;
    row_d        = row_q;

    // col_q/row_q count remaining words in the row and remaining rows,
    // so the final word is the one where both are at 1.
    last_col   = (col_q == DIM_W'(1));
    last_word  = last_col && (row_q == DIM_W'(1));
    src_row_nx = src_row_q + ADDR_W'(src_stride_q);
    dst_row_nx = dst_row_q + ADDR_W'(dst_stride_q);
    src_step   = last_col ? src_row_nx : src_ptr_q + ADDR_W'(4);
    dst_step   = last_col ? dst_row_nx : dst_ptr_q + ADDR_W'(4);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = mode;
          wstrb_cfg_d  = fill_wstrb;
          src_row_d    = src_base_a;
          src_ptr_d    = src_base_a;
          dst_row_d    = dst_base_a;
          dst_ptr_d    = dst_base_a;
          src_stride_d = src_stride;
          dst_stride_d = dst_stride;
          width_d      = width;
          col_d        = width;
          row_d        = height;
          // In copy mode this is overwritten by the first read before use.
          wdata_d      = fill_data;
          aborted_d    = 1'b0;
          if (width == '0 || height == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            sel_d  = 1'b1;
            if (mode) begin
              state_d = S_READ;
              wstrb_d = '0;
              addr_d  = src_base_a;
            end else begin
              state_d = S_WRITE;
              wstrb_d = fill_wstrb;
              addr_d  = dst_base_a;
            end
          end
        end
      end
      S_READ: begin
        if (ready) begin
          wdata_d = rdata;
          sel_d   = 1'b0;
          state_d = S_GAP_R;
        end
      end
      S_GAP_R: begin
        state_d = S_WRITE;
        sel_d   = 1'b1;
        wstrb_d = wstrb_cfg_q;
        addr_d  = dst_ptr_q;
      end
      S_WRITE: begin
        if (ready) begin
          sel_d   = 1'b0;
          wstrb_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (last_word || abort) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          aborted_d = !last_word;
        end else begin
          src_ptr_d = src_step;
          dst_ptr_d = dst_step;
          if (last_col) begin
            src_row_d = src_row_nx;
            dst_row_d = dst_row_nx;
            col_d     = width_q;
            row_d     = row_q - DIM_W'(1);
          end else begin
            col_d = col_q - DIM_W'(1);
          end
          sel_d = 1'b1;
          if (mode_q) begin
            state_d = S_READ;
            wstrb_d = '0;
            addr_d  = src_step;
          end else begin
            state_d = S_WRITE;
            wstrb_d = wstrb_cfg_q;
            addr_d  = dst_step;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      sel_q        <= 1'b0;
      mode_q       <= 1'b0;
      wstrb_q      <= '0;
      wstrb_cfg_q  <= '0;
      addr_q       <= '0;
      src_row_q    <= '0;
      src_ptr_q    <= '0;
      dst_row_q    <= '0;
      dst_ptr_q    <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      wdata_q      <= '0;
      width_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      sel_q        <= sel_d;
      mode_q       <= mode_d;
      wstrb_q      <= wstrb_d;
      wstrb_cfg_q  <= wstrb_cfg_d;
      addr_q       <= addr_d;
      src_row_q    <= src_row_d;
      src_ptr_q    <= src_ptr_d;
      dst_row_q    <= dst_row_d;
      dst_ptr_q    <= dst_ptr_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign sel     = sel_q;
  assign wstrb   = wstrb_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_vga_blit.sv
// tb_vga_blit: self-checking bench for vga_blit. A bus responder with
// configurable latency serves a sparse memory; a rectangle-level reference
// model predicts the beat list, the done cycle and the abort flag.
module tb_vga_blit;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 9;

  logic          clk = 1'b0;
  logic          reset, start, abort, mode;
  logic [AW-1:0] src_base, dst_base;
  logic [DW-1:0] width, height;
  logic [15:0]   src_stride, dst_stride;
  logic [31:0]   fill_data;
  logic [3:0]    fill_wstrb;
  logic          busy, done, aborted, sel;
  logic [3:0]    wstrb;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic [31:0]   rdata;

  vga_blit #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .width(width), .height(height),
    .src_stride(src_stride), .dst_stride(dst_stride), .fill_data(fill_data),
    .fill_wstrb(fill_wstrb), .busy(busy), .done(done), .aborted(aborted),
    .sel(sel), .wstrb(wstrb), .addr(addr), .wdata(wdata), .ready(ready),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode; logic [AW-1:0] src, dst; int unsigned w, h;
    logic [15:0] ss, ds; logic [31:0] fill; logic [3:0] ws; int unsigned lat;
  } cfg_t;
  typedef struct {
    cfg_t c; int unsigned abort_at, restart_at, exp_beats, exp_done;
    bit exp_ab; logic [AW-1:0] exp_last;
  } vec_t;
  typedef struct { bit wr; logic [AW-1:0] a; logic [31:0] d; logic [3:0] s; } beat_t;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t seen[$];
  beat_t expq[$];
  logic [31:0] mem     [logic [AW-1:0]];
  logic [31:0] ref_mem [logic [AW-1:0]];
  int unsigned lat = 1;
  int unsigned resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(logic [AW-1:0] a);
    return {a[7:0], a} ^ 32'h5A3C_96E1;
  endfunction
  function automatic logic [31:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic cfg_t mkcfg(bit m, logic [AW-1:0] s, logic [AW-1:0] d, int unsigned w,
                                 int unsigned h, logic [15:0] ss, logic [15:0] ds,
                                 logic [31:0] f, logic [3:0] ws, int unsigned l);
    cfg_t c;
    c.mode = m; c.src = s; c.dst = d; c.w = w; c.h = h;
    c.ss = ss; c.ds = ds; c.fill = f; c.ws = ws; c.lat = l;
    return c;
  endfunction
  function automatic vec_t mkvec(cfg_t c, int unsigned ab_at, int unsigned rs_at,
                                 int unsigned nb, int unsigned dc, bit ab, logic [AW-1:0] la);
    vec_t v;
    v.c = c; v.abort_at = ab_at; v.restart_at = rs_at; v.exp_beats = nb;
    v.exp_done = dc; v.exp_ab = ab; v.exp_last = la;
    return v;
  endfunction

  // Responder: ready arrives lat cycles after sel rises; fields must hold.
  initial begin
    logic [3:0] s0; logic [AW-1:0] a0; logic [31:0] d0; beat_t b;
    ready = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (sel === 1'b1) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          s0 = wstrb; a0 = addr; d0 = wdata;
        end else begin
          check("beat_stable", {wstrb, addr, wdata}, {s0, a0, d0});
        end
        if (resp_cnt == lat + 1) begin
          ready = 1'b1;
          b.wr = (wstrb != 4'h0); b.a = addr; b.s = wstrb;
          if (b.wr) begin
            b.d = wdata;
            mem[addr] = merge(mem_rd(addr), wdata, wstrb);
          end else begin
            rdata = mem_rd(addr);
            b.d = rdata;
          end
          seen.push_back(b);
        end else begin
          ready = 1'b0;
          rdata = $urandom;
        end
      end else begin
        resp_cnt = 0;
        ready = 1'b0;
        rdata = $urandom;
      end
    end
  end

  // Reference model: walk the rectangle row by row, word by word.
  task automatic build_expected(input cfg_t c, input int unsigned nwords);
    int unsigned k;
    longint unsigned ts, td;
    beat_t b;
    logic [AW-1:0] sa, da;
    logic [31:0] d;
    k = 0;
    expq.delete();
    for (int unsigned r = 0; r < c.h; r++) begin
      for (int unsigned x = 0; x < c.w; x++) begin
        if (k < nwords) begin
          ts = {c.src[AW-1:2], 2'b00};
          td = {c.dst[AW-1:2], 2'b00};
          ts = ts + longint'(r) * c.ss + 4 * x;
          td = td + longint'(r) * c.ds + 4 * x;
          sa = ts[AW-1:0];
          da = td[AW-1:0];
          d = c.fill;
          if (c.mode) begin
            d = ref_rd(sa);
            b.wr = 1'b0; b.a = sa; b.d = d; b.s = 4'h0;
            expq.push_back(b);
          end
          b.wr = 1'b1; b.a = da; b.d = d; b.s = c.ws;
          expq.push_back(b);
          ref_mem[da] = merge(ref_rd(da), d, c.ws);
          k++;
        end
      end
    end
  endtask

  task automatic run_op(input cfg_t c, input int unsigned abort_at, input int unsigned restart_at,
                        input string tag, output int unsigned done_k, output bit ab_seen);
    int unsigned per, total, nexp, exp_done, k;
    bit prof_bad;
    lat = c.lat;
    per = (c.lat + 2) * (c.mode ? 2 : 1);
    total = c.w * c.h;
    nexp = total;
    if (abort_at != 0) begin
      nexp = (abort_at - 1) / per + 1;
      if (nexp > total) nexp = total;
    end
    exp_done = (total == 0) ? 1 : nexp * per + 1;
    build_expected(c, nexp);
    seen.delete();
    @(negedge clk);
    mode = c.mode; src_base = c.src; dst_base = c.dst; width = DW'(c.w); height = DW'(c.h);
    src_stride = c.ss; dst_stride = c.ds; fill_data = c.fill; fill_wstrb = c.ws;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble configuration: the running operation must not see it.
    mode = ~c.mode; src_base = AW'($urandom); dst_base = AW'($urandom);
    width = DW'($urandom); height = DW'($urandom); src_stride = 16'($urandom);
    dst_stride = 16'($urandom); fill_data = $urandom; fill_wstrb = 4'($urandom);
    k = 1;
    prof_bad = 1'b0;
    check({tag, "_aborted_clr"}, aborted, 0);
    while (done !== 1'b1 && k <= exp_done + 20) begin
      if (busy !== (total != 0)) prof_bad = 1'b1;
      if (abort_at != 0 && k == abort_at) abort = 1'b1;
      start = (restart_at != 0 && k == restart_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    abort = 1'b0;
    done_k = k;
    ab_seen = aborted;
    check({tag, "_done_cycle"}, k, exp_done);
    check({tag, "_aborted"}, aborted, nexp < total);
    check({tag, "_busy_sel_at_done"}, {busy, sel}, 0);
    check({tag, "_busy_profile"}, prof_bad, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_nbeats"}, seen.size(), expq.size());
    for (int i = 0; i < expq.size() && i < seen.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), {seen[i].wr, seen[i].a, seen[i].d, seen[i].s},
            {expq[i].wr, expq[i].a, expq[i].d, expq[i].s});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int unsigned dk;
    bit ab;
    cfg_t c;
    logic [AW-1:0] fa [8];
    int unsigned per, tot, abat;

    vt[0] = mkvec(mkcfg(0, 24'h0, 24'h000100, 4, 2, 16'h0, 16'h40, 32'hDEADBEEF, 4'hF, 1),
                  0, 0, 8, 25, 0, 24'h00014C);
    vt[1] = mkvec(mkcfg(1, 24'h020000, 24'h0, 2, 1, 16'h0, 16'h0, 32'h0, 4'hF, 1),
                  0, 0, 4, 13, 0, 24'h000004);
    vt[2] = mkvec(mkcfg(0, 24'h0, 24'h000200, 0, 5, 16'h0, 16'h0, 32'h1, 4'hF, 1),
                  0, 0, 0, 1, 0, 24'h0);
    vt[3] = mkvec(mkcfg(0, 24'h0, 24'h003000, 8, 1, 16'h0, 16'h0, 32'hCAFEF00D, 4'hF, 5),
                  10, 4, 2, 15, 1, 24'h003004);
    vt[4] = mkvec(mkcfg(0, 24'h0, 24'hFFFFFC, 2, 1, 16'h0, 16'h0, 32'h12345678, 4'hF, 1),
                  0, 0, 2, 7, 0, 24'h000000);
    vt[5] = mkvec(mkcfg(1, 24'h008000, 24'h000500, 3, 2, 16'h20, 16'h20, 32'h0, 4'h5, 2),
                  10, 0, 4, 17, 1, 24'h000504);
    vt[6] = mkvec(mkcfg(1, 24'h0, 24'h0, 3, 0, 16'h0, 16'h0, 32'h0, 4'hF, 1),
                  0, 0, 0, 1, 0, 24'h0);
    vt[7] = mkvec(mkcfg(0, 24'h0, 24'h000010, 1, 3, 16'h0, 16'h100, 32'hA5A5A5A5, 4'h3, 0),
                  0, 0, 3, 7, 0, 24'h000210);
    vt[8] = mkvec(mkcfg(0, 24'h0, 24'h000123, 2, 1, 16'h0, 16'h0, 32'h0F0F0F0F, 4'hF, 1),
                  0, 0, 2, 7, 0, 24'h000124);

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_base = '0; dst_base = '0; width = '0; height = '0;
    src_stride = '0; dst_stride = '0; fill_data = '0; fill_wstrb = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {sel, wstrb, addr, wdata, busy, done, aborted}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {sel, busy, done, aborted}, 0);

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].c, vt[i].abort_at, vt[i].restart_at, $sformatf("vec%0d", i), dk, ab);
      check($sformatf("vec%0d_tbl_done", i), dk, vt[i].exp_done);
      check($sformatf("vec%0d_tbl_aborted", i), ab, vt[i].exp_ab);
      check($sformatf("vec%0d_tbl_nbeats", i), seen.size(), vt[i].exp_beats);
      if (vt[i].exp_beats != 0 && seen.size() != 0)
        check($sformatf("vec%0d_tbl_last_addr", i), seen[$].a, vt[i].exp_last);
    end

    // Fill address sequence written out explicitly.
    fa = '{24'h100, 24'h104, 24'h108, 24'h10C, 24'h140, 24'h144, 24'h148, 24'h14C};
    run_op(vt[0].c, 0, 0, "fill_seq", dk, ab);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check($sformatf("fill_seq_w%0d", i), {seen[i].wr, seen[i].a, seen[i].d},
            {1'b1, fa[i], 32'hDEADBEEF});

    // Copy beat order with known source contents.
    mem[24'h020000] = 32'h11111111; ref_mem[24'h020000] = 32'h11111111;
    mem[24'h020004] = 32'h22222222; ref_mem[24'h020004] = 32'h22222222;
    run_op(vt[1].c, 0, 0, "copy_seq", dk, ab);
    if (seen.size() == 4) begin
      check("copy_seq_r0", {seen[0].wr, seen[0].a}, {1'b0, 24'h020000});
      check("copy_seq_w0", {seen[1].wr, seen[1].a, seen[1].d}, {1'b1, 24'h000000, 32'h11111111});
      check("copy_seq_r1", {seen[2].wr, seen[2].a}, {1'b0, 24'h020004});
      check("copy_seq_w1", {seen[3].wr, seen[3].a, seen[3].d}, {1'b1, 24'h000004, 32'h22222222});
    end else begin
      check("copy_seq_count", seen.size(), 4);
    end

    // Abort while idle has no effect.
    abort = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_abort", {busy, sel, done}, 0);
    abort = 1'b0;

    // Reset during a stalled beat drops everything immediately.
    lat = 1000;
    mode = 1'b0; dst_base = 24'h000800; width = 9'd4; height = 9'd1;
    fill_data = 32'h77777777; fill_wstrb = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_sel_high", {sel, busy}, 2'b11);
    #2 reset = 1'b1;
    #1 check("reset_async", {sel, busy, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(mkcfg(0, 24'h0, 24'h000900, 3, 1, 16'h0, 16'h0, 32'h600DF00D, 4'hF, 1),
           0, 0, "after_reset", dk, ab);

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      c = mkcfg(1'($urandom), AW'(24'hFFFE00 + $urandom_range(0, 1023)),
                AW'(24'hFFFE00 + $urandom_range(0, 1023)), $urandom_range(0, 4),
                $urandom_range(0, 3), 16'($urandom_range(0, 255)), 16'($urandom),
                $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3));
      per = (c.lat + 2) * (c.mode ? 2 : 1);
      tot = c.w * c.h;
      abat = 0;
      if (tot != 0 && $urandom_range(0, 3) == 0) abat = $urandom_range(1, tot * per);
      run_op(c, abat, (tot != 0) ? 2 : 0, $sformatf("rnd%0d", n), dk, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_blit.md
# vga_blit

Rectangle fill/copy engine that masters the picosoc MMIO bus (`sel`/`ready`/`wstrb`/`addr`/`wdata`/`rdata`) from the initiator side, driving the VGA core's VRAM and font-RAM responder. The CPU programs a rectangle and starts the engine. The engine then issues one 32-bit bus beat per word: either a pattern write (fill), or a read followed by a write (copy). It sits beside the CPU on the bus arbiter as a second initiator.

## Interface
- `ADDR_W`, 24: bus address width; all address arithmetic is modulo 2^ADDR_W.
- `DIM_W`, 9: width of the `width`/`height` counters, in words and rows.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: level; stops the operation after the current beat.
- `mode` in 1: 0 = fill, 1 = copy.
- `src_base` in ADDR_W: copy source byte address; bits [1:0] are ignored (treated as 0).
- `dst_base` in ADDR_W: destination byte address; bits [1:0] are ignored.
- `width` in DIM_W: words per row; 0 means nothing to do.
- `height` in DIM_W: number of rows; 0 means nothing to do.
- `src_stride`, `dst_stride` in 16: byte distance between row starts, unsigned.
- `fill_data` in 32: fill pattern.
- `fill_wstrb` in 4: byte enables used on every write, in both modes.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the operation ends.
- `aborted` out 1: set with `done` if the operation ended by abort; cleared on the next accepted `start`.
- `sel` out 1: bus request.
- `wstrb` out 4: 0 = read beat, otherwise write beat.
- `addr` out ADDR_W: beat address.
- `wdata` out 32: write data.
- `ready` in 1: responder completion pulse.
- `rdata` in 32: read data, valid in the same cycle as `ready`.

## Operation
- Reset values: `sel`=0, `wstrb`=0, `addr`=0, `wdata`=0, `busy`=0, `done`=0, `aborted`=0; state is IDLE.
- All configuration inputs are latched when `start` is accepted; later changes have no effect on the running operation.
- States and transitions:
  - IDLE: on `start`, go to READ if `mode`=1, else WRITE. If `width` or `height` is 0, go directly to DONE.
  - READ: `sel`=1, `wstrb`=0, `addr`=current source address. When `ready`=1, capture `rdata` into the data register and go to GAP_R.
  - GAP_R: `sel`=0 for exactly one cycle, then go to WRITE.
  - WRITE: `sel`=1, `wstrb`=latched `fill_wstrb`, `addr`=current destination address. `wdata` is the latched `fill_data` (fill) or the captured read data (copy). When `ready`=1, go to GAP.
  - GAP: `sel`=0 for exactly one cycle; advance the counters. If this was the last word, or `abort` is high, go to DONE; otherwise go to READ (copy) or WRITE (fill).
  - DONE: pulse `done` for one cycle, drop `busy`, go to IDLE.
- Bus rules:
  - `sel` and the beat fields (`wstrb`, `addr`, `wdata`) stay stable from the first cycle of `sel` through the `ready` cycle.
  - `sel` always drops for at least one cycle between beats, because the responder rearms its read path only while `sel`=0.
  - Beats are never abandoned: `abort` takes effect only in GAP, and a copy that is aborted during READ still completes its WRITE.
  - There is no timeout; a responder that never asserts `ready` stalls the engine until `reset`.
- Address arithmetic:
  - Within a row, each address advances by 4.
  - At end of row, the address becomes row start + stride, and the word counter reloads to `width`.
  - All address sums wrap modulo 2^ADDR_W.
  - Beats in a row: `width`. Rows: `height`. Total beats: width×height (fill) or 2×width×height (copy).
- `start` while `busy` is ignored. `abort` while IDLE is ignored.

## Timing
- The first `sel` is asserted in the cycle after `start` is accepted.
- A beat whose responder asserts `ready` L cycles after `sel` rises occupies L+1 cycles for `sel` plus 1 gap cycle.
  - With L=1: fill costs 3 cycles per word; copy costs 6 cycles per word.
- `done` is asserted in the cycle after the final GAP.
- For a zero-size operation, `done` is asserted 1 cycle after `start`, and `sel` never rises.
- A `reset` assertion mid-beat drops `sel` asynchronously, in the same cycle.

## Test plan
- Fill, width=4, height=2, `dst_base`=0x000100, `dst_stride`=0x40, `fill_data`=0xDEADBEEF, `fill_wstrb`=0xF, responder with L=1:
  - Exactly 8 writes, to 0x100, 0x104, 0x108, 0x10C, 0x140, 0x144, 0x148, 0x14C.
  - `sel` low between every pair of beats; one `done` pulse in cycle 25 after `start`; `aborted`=0.
- Copy, width=2, height=1, `src_base`=0x020000, `dst_base`=0x000000, memory model holds 0x11111111 and 0x22222222 at the source:
  - Beat order is R 0x020000, W 0x000000 = 0x11111111, R 0x020004, W 0x000004 = 0x22222222.
- Zero size, width=0, height=5:
  - `done` at start+1; `sel` never asserted; `busy` is never high.
- Abort, fill width=8, height=1, responder with L=5, `abort` raised during the 2nd beat:
  - The 2nd beat completes with stable fields; no 3rd beat is issued; `done` and `aborted`=1.
  - A second `start` asserted while `busy` is ignored.
- Wrap, `dst_base`=0xFFFFFC, width=2:
  - The second write goes to address 0x000000.
- Reset mid-beat, asserted while `sel`=1:
  - `sel`, `busy` and `done` all read 0 in the same cycle; the next `start` runs normally.
